// File: rtl/sigdelay_pkg.sv
// rtl/sigdelay_pkg.sv - shared types, defaults and depth helper for the sigdelay sequencer
package sigdelay_pkg;

    localparam int unsigned DEF_A_WIDTH = 8;
    localparam int unsigned DEF_D_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        RUN    = 2'd2,
        RETUNE = 2'd3
    } state_t;

    // Delay depth D = 2^aw - off. Offset 0 wraps to the full RAM depth.
    // Returned 32 bits wide; callers keep the low aw+1 bits.
    function automatic logic [31:0] depth_of(input int unsigned aw, input logic [31:0] off);
        return (32'd1 << aw) - off;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Ports: clk, rst (async, active-high), inc (count enable), clr (clear, wins over inc),
//        count (current value, stops at MAX).
module sat_counter #(
    parameter int unsigned     WIDTH = 9,
    parameter logic [WIDTH-1:0] MAX  = {1'b1, {(WIDTH-1){1'b0}}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sigdelay_ctrl.sv
// rtl/sigdelay_ctrl.sv - write/read sequencer and fill tracking for the sigdelay delay line
// Ports: clk, rst (async, active-high), en (run level), offset_req (requested offset),
//        wr/rd (RAM enables), offset (applied offset), fill_cnt (writes since start,
//        saturating at 2^A_WIDTH), delayed_valid (rd delayed by RAM latency), state (debug).
module sigdelay_ctrl
    import sigdelay_pkg::*;
#(
    parameter int unsigned A_WIDTH = DEF_A_WIDTH,
    parameter int unsigned D_WIDTH = DEF_D_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [A_WIDTH-1:0] offset_req,
    output logic               wr,
    output logic               rd,
    output logic [A_WIDTH-1:0] offset,
    output logic [A_WIDTH:0]   fill_cnt,
    output logic               delayed_valid,
    output logic [1:0]         state
);

    if (A_WIDTH < 1 || A_WIDTH > 30 || D_WIDTH < 1) begin : g_bad_param
        $error("sigdelay_ctrl: unsupported A_WIDTH/D_WIDTH");
    end

    state_t st;

    logic [31:0]       d_req_full;
    logic [31:0]       d_cur_full;
    logic [A_WIDTH:0]  d_req;
    logic [A_WIDTH:0]  d_cur;
    logic [A_WIDTH+1:0] fill_next;

    // FILL judges against the requested offset so a change there takes effect at once;
    // RETUNE judges against the offset just applied on entry.
    assign d_req_full = depth_of(A_WIDTH, {{(32-A_WIDTH){1'b0}}, offset_req});
    assign d_cur_full = depth_of(A_WIDTH, {{(32-A_WIDTH){1'b0}}, offset});
    assign d_req      = d_req_full[A_WIDTH:0];
    assign d_cur      = d_cur_full[A_WIDTH:0];
    assign fill_next  = {1'b0, fill_cnt} + 1'b1;

    assign state = st;

    // Clearing whenever en is low covers both the entry edge into IDLE and the IDLE dwell,
    // so a restart always refills from zero and stale RAM data is never flagged valid.
    sat_counter #(
        .WIDTH (A_WIDTH + 1),
        .MAX   ({1'b1, {A_WIDTH{1'b0}}})
    ) u_fill_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (wr),
        .clr   (~en),
        .count (fill_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st            <= IDLE;
            wr            <= 1'b0;
            rd            <= 1'b0;
            delayed_valid <= 1'b0;
            offset        <= '0;
        end else begin
            // RAM read latency is one cycle.
            delayed_valid <= rd;
            if (!en) begin
                st <= IDLE;
                wr <= 1'b0;
                rd <= 1'b0;
                if (st == IDLE) begin
                    offset <= offset_req;
                end
            end else begin
                case (st)
                    IDLE: begin
                        st     <= FILL;
                        wr     <= 1'b1;
                        rd     <= 1'b0;
                        offset <= offset_req;
                    end
                    FILL: begin
                        wr     <= 1'b1;
                        offset <= offset_req;
                        // This cycle's write makes fill_cnt+1 samples; enough once it covers D.
                        if (fill_next >= {1'b0, d_req}) begin
                            st <= RUN;
                            rd <= 1'b1;
                        end else begin
                            rd <= 1'b0;
                        end
                    end
                    RUN: begin
                        wr <= 1'b1;
                        if (offset_req != offset) begin
                            st     <= RETUNE;
                            rd     <= 1'b0;
                            offset <= offset_req;
                        end else begin
                            rd <= 1'b1;
                        end
                    end
                    RETUNE: begin
                        wr <= 1'b1;
                        // Shorter delay: data already present. Longer: refill the gap.
                        if (fill_cnt >= d_cur) begin
                            st <= RUN;
                            rd <= 1'b1;
                        end else begin
                            st <= FILL;
                            rd <= 1'b0;
                        end
                    end
                    default: begin
                        st <= IDLE;
                        wr <= 1'b0;
                        rd <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sigdelay_ctrl.sv
// tb/tb_sigdelay_ctrl.sv - directed self-checking bench for sigdelay_ctrl
module tb_sigdelay_ctrl;

    localparam int unsigned AW = 8;

    logic          clk;
    logic          rst;
    logic          en;
    logic [AW-1:0] offset_req;
    logic          wr;
    logic          rd;
    logic [AW-1:0] offset;
    logic [AW:0]   fill_cnt;
    logic          delayed_valid;
    logic [1:0]    state;

    int n_checks;
    int n_errors;

    sigdelay_ctrl #(
        .A_WIDTH (AW),
        .D_WIDTH (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .offset_req    (offset_req),
        .wr            (wr),
        .rd            (rd),
        .offset        (offset),
        .fill_cnt      (fill_cnt),
        .delayed_valid (delayed_valid),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One cycle: active edge, then settle at the falling edge where inputs and samples happen.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_wr"}, wr, 0);
        check({tag, "_rd"}, rd, 0);
        check({tag, "_dv"}, delayed_valid, 0);
        check({tag, "_fill"}, fill_cnt, 0);
    endtask

    initial begin
        int first_rd;
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        en         = 1'b0;
        offset_req = '0;
        #1;
        check_idle("por");
        check("por_offset", offset, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        check_idle("idle");

        // Start fill, offset 192 -> D = 64. Cycle 0 is this falling edge.
        offset_req = 8'd192;
        en         = 1'b1;
        check("c0_wr", wr, 0);
        tick(1);
        check("c1_wr", wr, 1);
        check("c1_state", state, 1);
        check("c1_offset", offset, 192);
        check("c1_fill", fill_cnt, 0);
        tick(63);
        check("c64_rd", rd, 0);
        check("c64_fill", fill_cnt, 63);
        tick(1);
        check("c65_rd", rd, 1);
        check("c65_state", state, 2);
        check("c65_dv", delayed_valid, 0);
        tick(1);
        check("c66_dv", delayed_valid, 1);
        tick(194);
        check("c260_fill_sat", fill_cnt, 256);
        check("c260_rd", rd, 1);

        // Shorter-delay retune 192 -> 224 (D = 32).
        offset_req = 8'd224;
        tick(1);
        check("rt_state", state, 3);
        check("rt_rd", rd, 0);
        check("rt_wr", wr, 1);
        check("rt_offset", offset, 224);
        check("rt_dv", delayed_valid, 1);
        tick(1);
        check("rt1_state", state, 2);
        check("rt1_rd", rd, 1);
        check("rt1_dv_gap", delayed_valid, 0);
        tick(1);
        check("rt2_dv", delayed_valid, 1);

        // Asynchronous reset mid-RUN.
        rst        = 1'b1;
        en         = 1'b0;
        offset_req = '0;
        #1;
        check_idle("arst");
        check("arst_offset", offset, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(3);
        check_idle("arst_rel");
        check("arst_rel_offset", offset, 0);

        // Longer-delay retune: D = 16, run, then offset 0 (D = 256).
        offset_req = 8'd240;
        en         = 1'b1;
        tick(17);
        check("lr_c17_rd", rd, 1);
        tick(20);
        check("lr_c37_state", state, 2);
        check("lr_c37_fill", fill_cnt, 36);
        offset_req = 8'd0;
        tick(1);
        check("lr_rt_state", state, 3);
        check("lr_rt_offset", offset, 0);
        check("lr_rt_rd", rd, 0);
        tick(1);
        check("lr_fill_state", state, 1);
        check("lr_fill_rd", rd, 0);
        check("lr_fill_cnt", fill_cnt, 38);
        tick(217);
        check("lr_c256_state", state, 1);
        check("lr_c256_rd", rd, 0);
        check("lr_c256_fill", fill_cnt, 255);
        tick(1);
        check("lr_c257_state", state, 2);
        check("lr_c257_rd", rd, 1);
        check("lr_c257_fill", fill_cnt, 256);

        // Stop in RUN.
        en = 1'b0;
        tick(1);
        check_idle_partial: begin
            check("stop_state", state, 0);
            check("stop_wr", wr, 0);
            check("stop_rd", rd, 0);
            check("stop_fill", fill_cnt, 0);
            check("stop_dv", delayed_valid, 1);
        end
        tick(1);
        check("stop_dv_fall", delayed_valid, 0);

        // Restart with D = 256: first rd must come 256 cycles after first wr.
        en       = 1'b1;
        first_rd = -1;
        for (int c = 1; c <= 300; c++) begin
            tick(1);
            if (c == 1) check("rs_c1_wr", wr, 1);
            if (rd && first_rd < 0) first_rd = c;
            if (first_rd >= 0) break;
        end
        check("rs_first_rd_cycle", first_rd, 257);

        // Priority: en drop and offset change together in RUN.
        en         = 1'b0;
        offset_req = 8'd100;
        tick(1);
        check("pr_state", state, 0);
        check("pr_wr", wr, 0);
        check("pr_rd", rd, 0);
        tick(1);
        check("pr_offset_follow", offset, 100);
        offset_req = 8'd7;
        tick(1);
        check("pr_offset_follow2", offset, 7);
        check("pr_state2", state, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
